// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes LEGv8 operation descriptors and streams them into imem
// Optional feature: ENC_ILLEGAL_TRAP_EN (drop illegal op_sel and raise a sticky err).
module instr_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [25:0]       imm,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic [ADDR_W:0]   word_cnt,
`ifdef ENC_ILLEGAL_TRAP_EN
    output logic              err,
`endif
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    logic [1:0]      state;
    logic [ADDR_W:0] issued;
    logic            accept;
    logic            keep;
    logic            start_ok;
    logic [31:0]     enc;

    // A word still sitting in the write register counts as issued.
    assign issued   = word_cnt + {{ADDR_W{1'b0}}, we};
    assign in_ready = (state == ST_LOAD) && (issued < DEPTH_W);
    assign accept   = in_valid && in_ready;
    assign start_ok = start && !stop && (state != ST_LOAD);
    assign busy     = (state != ST_IDLE);

`ifdef ENC_ILLEGAL_TRAP_EN
    logic legal;
    assign legal = (op_sel <= 4'd9);
    assign keep  = accept && legal;
`else
    assign keep  = accept;
`endif

    always_comb begin
        enc = 32'h0000_0000;
        case (op_sel)
            4'd0: enc = {11'b10001011000, rm, 6'b000000, rn, rd};
            4'd1: enc = {11'b11001011000, rm, 6'b000000, rn, rd};
            4'd2: enc = {11'b10001010000, rm, 6'b000000, rn, rd};
            4'd3: enc = {11'b10101010000, rm, 6'b000000, rn, rd};
            4'd4: enc = {10'b1001000100, imm[11:0], rn, rd};
            4'd5: enc = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
            4'd6: enc = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
            4'd7: enc = {8'b10110100, imm[18:0], rd};
            4'd8: enc = {8'b10110101, imm[18:0], rd};
            4'd9: enc = {6'b000101, imm};
            default: enc = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= 32'h0000_0000;
            word_cnt <= '0;
        end else begin
            we <= keep;
            if (keep) begin
                waddr <= issued[ADDR_W-1:0];
                wdata <= enc;
            end else if (start_ok) begin
                waddr <= '0;
            end

            if (start_ok)
                word_cnt <= '0;
            else if (we)
                word_cnt <= word_cnt + ONE_W;

            case (state)
                ST_IDLE: if (start_ok) state <= ST_LOAD;
                ST_LOAD: begin
                    if (stop)
                        state <= ST_IDLE;
                    else if (keep && (issued == DEPTH_W - ONE_W))
                        state <= ST_FULL;
                end
                ST_FULL: begin
                    if (stop)
                        state <= ST_IDLE;
                    else if (start_ok)
                        state <= ST_LOAD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ENC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (start_ok)
            err <= 1'b0;
        else if (accept && !legal)
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder
module tb_instr_encoder;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef ENC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk, reset, start, stop, in_valid, in_ready;
    logic [3:0]    op_sel;
    logic [4:0]    rd, rn, rm;
    logic [25:0]   imm;
    logic          we, busy;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [AW:0]   word_cnt;
`ifdef ENC_ILLEGAL_TRAP_EN
    logic          err;
`endif

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
        .rd(rd), .rn(rn), .rm(rm), .imm(imm), .we(we), .waddr(waddr),
        .wdata(wdata), .word_cnt(word_cnt),
`ifdef ENC_ILLEGAL_TRAP_EN
        .err(err),
`endif
        .busy(busy)
    );

    typedef struct { int cyc; int addr; logic [31:0] data; } wr_t;
    wr_t obs_q[$];
    wr_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference state: loading flag, words accepted since start, sticky error.
    bit m_busy = 0;
    int m_cnt  = 0;
    bit m_err  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (reset && we) obs_q.push_back('{cyc, int'(waddr), wdata});

    function automatic logic [31:0] ref_enc(int op, int d, int n, int m, int im);
        longint r;
        longint p21 = 2097152;
        longint ds = d % 32;
        longint ns = (n % 32) * 32;
        longint ms = (m % 32) * 65536;
        case (op)
            0: r = 1112 * p21 + ms + ns + ds;
            1: r = 1624 * p21 + ms + ns + ds;
            2: r = 1104 * p21 + ms + ns + ds;
            3: r = 1360 * p21 + ms + ns + ds;
            4: r = 580 * 2 * p21 + (im % 4096) * 1024 + ns + ds;
            5: r = 1986 * p21 + (im % 512) * 4096 + ns + ds;
            6: r = 1984 * p21 + (im % 512) * 4096 + ns + ds;
            7: r = 180 * 8 * p21 + (im % 524288) * 32 + ds;
            8: r = 181 * 8 * p21 + (im % 524288) * 32 + ds;
            9: r = 5 * 32 * p21 + (im % 67108864);
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic step(input bit v, input int op, input int d, input int n, input int m,
                        input int im, input bit st, input bit sp,
                        output bit rdy_dut, output bit rdy_ref);
        bit acc;
        in_valid = v; op_sel = op[3:0]; rd = d[4:0]; rn = n[4:0]; rm = m[4:0];
        imm = im[25:0]; start = st; stop = sp;
        #1;
        rdy_dut = in_ready;
        rdy_ref = m_busy && (m_cnt < DEPTH);
        acc = v && rdy_ref;
        @(posedge clk);
        #1;
        if (acc) begin
            if (TRAP && op > 9) m_err = 1;
            else begin
                exp_q.push_back('{cyc, m_cnt, ref_enc(op, d, n, m, im)});
                m_cnt++;
            end
        end
        if (sp) m_busy = 0;
        else if (st && (!m_busy || m_cnt == DEPTH)) begin
            m_busy = 1; m_cnt = 0; m_err = 0;
        end
        in_valid = 0; start = 0; stop = 0;
    endtask

    task automatic idle(input int k);
        bit a, b;
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a, b);
    endtask

    task automatic test_reset();
        bit a, b;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({we, busy, in_ready} !== 3'b000) $display("FAIL rst_ctl got %b want 000", {we, busy, in_ready}); else n_pass++;
        n_checks++; if ({waddr, wdata, word_cnt} !== '0) $display("FAIL rst_data got %h/%h/%h want 0", waddr, wdata, word_cnt); else n_pass++;
        reset = 1;
        step(0, 0, 0, 0, 0, 0, 1, 0, a, b);
        step(1, 0, 1, 2, 3, 0, 0, 0, a, b);
        step(1, 1, 4, 5, 6, 0, 0, 0, a, b);
        reset = 0;
        #1;
        n_checks++; if ({we, busy, in_ready} !== 3'b000) $display("FAIL midrst_ctl got %b want 000", {we, busy, in_ready}); else n_pass++;
        n_checks++; if ({waddr, wdata, word_cnt} !== '0) $display("FAIL midrst_data got %h/%h/%h want 0", waddr, wdata, word_cnt); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1;
        m_busy = 0; m_cnt = 0; m_err = 0;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            step(1, 4, 1, 1, 1, 5, 0, 0, a, b);
            n_checks++; if (a !== 1'b0) $display("FAIL nostart_ready got %b want 0", a); else n_pass++;
        end
        idle(1);
        n_checks++; if (obs_q.size() != 0) $display("FAIL nostart_writes got %0d want 0", obs_q.size()); else n_pass++;
    endtask

    task automatic test_single();
        bit a, b;
        obs_q.delete(); exp_q.delete();
        step(0, 0, 0, 0, 0, 0, 1, 0, a, b);
        step(1, 0, 1, 2, 3, 0, 0, 0, a, b);
        idle(2);
        n_checks++; if (obs_q.size() != 1) $display("FAIL add_count got %0d want 1", obs_q.size()); else n_pass++;
        if (obs_q.size() == 1 && exp_q.size() == 1) begin
            n_checks++; if (obs_q[0].data !== 32'h8B030041 || obs_q[0].addr != 0) $display("FAIL add_word got %0d:%h want 0:8b030041", obs_q[0].addr, obs_q[0].data); else n_pass++;
            n_checks++; if (obs_q[0].cyc != exp_q[0].cyc) $display("FAIL add_latency got cycle %0d want %0d", obs_q[0].cyc, exp_q[0].cyc); else n_pass++;
        end
        n_checks++; if (word_cnt !== 4'd1) $display("FAIL add_wordcnt got %0d want 1", word_cnt); else n_pass++;
        step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
    endtask

    task automatic test_back_to_back();
        bit a, b;
        logic [31:0] want [3];
        want[0] = 32'h91002805; want[1] = 32'hF8408024; want[2] = 32'hB4000069;
        obs_q.delete(); exp_q.delete();
        step(0, 0, 0, 0, 0, 0, 1, 0, a, b);
        step(1, 4, 5, 0, 0, 12'h00A, 0, 0, a, b);
        step(1, 5, 4, 1, 0, 8, 0, 0, a, b);
        step(1, 7, 9, 0, 0, 3, 0, 0, a, b);
        idle(2);
        n_checks++; if (obs_q.size() != 3) $display("FAIL b2b_count got %0d want 3", obs_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].addr != i || obs_q[i].data !== want[i] || obs_q[i].cyc != obs_q[0].cyc + i)
                $display("FAIL b2b_word%0d got %0d:%h@%0d want %0d:%h@%0d", i, obs_q[i].addr, obs_q[i].data, obs_q[i].cyc, i, want[i], obs_q[0].cyc + i);
            else n_pass++;
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
    endtask

    task automatic test_full();
        bit a, b;
        obs_q.delete(); exp_q.delete();
        step(0, 0, 0, 0, 0, 0, 1, 0, a, b);
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1, $urandom_range(0, 9), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 26'h3FFFFFF), 0, 0, a, b);
            n_checks++; if (a !== b) $display("FAIL full_ready%0d got %b want %b", i, a, b); else n_pass++;
        end
        idle(2);
        n_checks++; if (obs_q.size() != DEPTH) $display("FAIL full_count got %0d want %0d", obs_q.size(), DEPTH); else n_pass++;
        if (obs_q.size() == DEPTH) begin
            n_checks++; if (obs_q[DEPTH-1].addr != DEPTH - 1) $display("FAIL full_lastaddr got %0d want %0d", obs_q[DEPTH-1].addr, DEPTH - 1); else n_pass++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i].data !== exp_q[i].data) $display("FAIL full_data%0d got %h want %h", i, obs_q[i].data, exp_q[i].data); else n_pass++;
        end
        n_checks++; if ({in_ready, busy} !== 2'b01) $display("FAIL full_state got rdy/busy %b want 01", {in_ready, busy}); else n_pass++;
        n_checks++; if (word_cnt !== 4'(DEPTH)) $display("FAIL full_wordcnt got %0d want %0d", word_cnt, DEPTH); else n_pass++;
        obs_q.delete(); exp_q.delete();
        step(0, 0, 0, 0, 0, 0, 1, 0, a, b);
        step(1, 3, 7, 8, 9, 0, 0, 0, a, b);
        idle(1);
        n_checks++; if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0].addr != 0)) $display("FAIL restart_addr got %0d writes want 1 at 0", obs_q.size()); else n_pass++;
        n_checks++; if (word_cnt !== 4'd1) $display("FAIL restart_wordcnt got %0d want 1", word_cnt); else n_pass++;
        step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
    endtask

    task automatic test_stop();
        bit a, b;
        obs_q.delete(); exp_q.delete();
        step(0, 0, 0, 0, 0, 0, 1, 0, a, b);
        step(1, 9, 0, 0, 0, 26'h3FFFFFF, 0, 1, a, b);
        idle(1);
        n_checks++; if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0].data !== 32'h17FFFFFF)) $display("FAIL stop_write got %0d writes want 1 of 17ffffff", obs_q.size()); else n_pass++;
        n_checks++; if ({busy, in_ready} !== 2'b00) $display("FAIL stop_idle got busy/rdy %b want 00", {busy, in_ready}); else n_pass++;
        step(0, 0, 0, 0, 0, 0, 1, 1, a, b);
        n_checks++; if (busy !== 1'b0) $display("FAIL startstop got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_illegal();
        bit a, b;
        obs_q.delete(); exp_q.delete();
        step(0, 0, 0, 0, 0, 0, 1, 0, a, b);
        step(1, 12, 3, 3, 3, 26'h155, 0, 0, a, b);
        idle(2);
`ifdef ENC_ILLEGAL_TRAP_EN
        n_checks++; if (obs_q.size() != 0) $display("FAIL trap_writes got %0d want 0", obs_q.size()); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL trap_err got %b want 1", err); else n_pass++;
        n_checks++; if (word_cnt !== 4'd0) $display("FAIL trap_wordcnt got %0d want 0", word_cnt); else n_pass++;
        step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
        step(0, 0, 0, 0, 0, 0, 1, 0, a, b);
        n_checks++; if (err !== 1'b0) $display("FAIL trap_clear got %b want 0", err); else n_pass++;
`else
        n_checks++; if (obs_q.size() != 1 || (obs_q.size() == 1 && (obs_q[0].data !== 32'h0 || obs_q[0].addr != 0))) $display("FAIL illegal_write got %0d writes want 1 zero word at 0", obs_q.size()); else n_pass++;
        n_checks++; if (word_cnt !== 4'd1) $display("FAIL illegal_wordcnt got %0d want 1", word_cnt); else n_pass++;
`endif
        step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
    endtask

    task automatic test_random();
        bit a, b;
        for (int r = 0; r < 3; r++) begin
            obs_q.delete(); exp_q.delete();
            step(0, 0, 0, 0, 0, 0, 1, 0, a, b);
            for (int i = 0; i < 14; i++) begin
                step(($urandom % 4) != 0, $urandom_range(0, 11), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 26'h3FFFFFF),
                     ($urandom % 8) == 0, 0, a, b);
                n_checks++; if (a !== b) $display("FAIL rnd_ready r%0d c%0d got %b want %b", r, i, a, b); else n_pass++;
            end
            step(0, 0, 0, 0, 0, 0, 0, 1, a, b);
            idle(1);
            n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_count r%0d got %0d want %0d", r, obs_q.size(), exp_q.size()); else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i].addr != exp_q[i].addr || obs_q[i].data !== exp_q[i].data || obs_q[i].cyc != exp_q[i].cyc)
                    $display("FAIL rnd_word r%0d i%0d got %0d:%h@%0d want %0d:%h@%0d", r, i, obs_q[i].addr, obs_q[i].data, obs_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
                else n_pass++;
            end
            n_checks++; if (int'(word_cnt) != m_cnt) $display("FAIL rnd_wordcnt r%0d got %0d want %0d", r, word_cnt, m_cnt); else n_pass++;
        end
    endtask

    initial begin
        reset = 0; start = 0; stop = 0; in_valid = 0;
        op_sel = 0; rd = 0; rn = 0; rm = 0; imm = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_stop();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
